opb_register_simulink2ppc_status: RTL and testbench
===================================================

# opb_register_simulink2ppc_status

Software-readable status register: the return path of the PPC-to-Simulink register, carrying a 32-bit value from user (Simulink) logic to the PowerPC over OPB. It captures a word whenever user logic strobes it, keeps a sticky "new data" flag, and counts captures and overruns. It acknowledges OPB reads and writes in the system's standard single-beat manner. Instances sit on the OPB alongside the existing software registers, one per design-side readback value.

## Interface
Parameters:
- C_BASEADDR, 32'h00000000, first byte address of the 256-byte window
- C_HIGHADDR, 32'h000000FF, last byte address of the window
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width
- C_FAMILY, "virtex6", target family string; carried through the wrapper with no effect on logic

Ports:
- OPB_Clk  in  1  the single clock; OPB and user logic share it
- OPB_Rst  in  1  asynchronous, active-low reset
- OPB_ABus  in  [0:31]  address, MSB-first
- OPB_BE  in  [0:3]  byte enables; ignored
- OPB_DBus  in  [0:31]  write data; ignored
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transfer in progress
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; Sl_DBus[31] is the LSB
- Sl_xferAck  out  1  transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
- user_data_in  in  [31:0]  value to capture
- user_valid  in  1  capture strobe, one word per high cycle

## Operation
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. OPB_ABus[29] selects the register; other offset bits alias.
- DATA register (offset 0x0, read-only):
  - Holds the last captured user_data_in.
  - A read acknowledge clears NEW.
  - Writes are acknowledged and ignored.
- STATUS register (offset 0x4):
  - bit 0: NEW.
  - bits 15:8: OVR, an 8-bit overrun count that saturates at 255.
  - bits 31:16: CNT, a 16-bit capture count that wraps from 0xFFFF to 0.
  - All other bits read 0.
  - A write acknowledge to STATUS clears OVR and CNT. NEW is unaffected.
- Capture: when user_valid=1, the hold register takes user_data_in, NEW is set, and CNT increments.
  - OVR increments if NEW was already 1 and NEW is not being cleared in the same cycle.
- Simultaneous events:
  - DATA read ack together with user_valid: the read returns the old word, NEW ends at 1, and no overrun is counted.
  - STATUS write ack together with user_valid: the clear wins, so OVR and CNT become 0. The hold register and NEW still update.
- Bus FSM:
  - IDLE -> ACK on a hit. Read data is muxed and registered on this transition.
  - ACK -> WAIT unconditionally.
  - WAIT -> IDLE when OPB_select=0.
  - In IDLE, a hit whose select has just dropped is never re-acked.
- Reset values: all registers, NEW, OVR, and CNT are 0; FSM is in IDLE; Sl_DBus=0; Sl_xferAck=0.
- Reset mid-transfer: the outputs go to 0 at once, asynchronously. The bus master's timeout handles the lost beat.

## Timing
- Sl_xferAck is high for exactly one cycle, the cycle after the hit is first sampled. Latency is 1 cycle.
- Sl_DBus carries valid data only in that ACK cycle. It is 0 in every other cycle, as required for the OPB OR-bus.
- Read data reflects register state at the hit-sample edge. A capture in that same cycle is not visible.
- Register effects of the acknowledge (NEW clear, OVR/CNT clear) take effect on the edge that ends the ACK cycle.
- Back-to-back transfers: a new ack requires select to deassert for at least 1 cycle (through WAIT).
- user_valid is accepted every cycle; there is no backpressure.

## Structure
- Shared package opb_sw_reg_pkg holds:
  - offset constants (DATA 0x0, STATUS 0x4),
  - STATUS field positions and widths,
  - the FSM state enum (IDLE, ACK, WAIT).
- One sub-module, opb_slave_ack_fsm, contains the address decode and the ack/data-gating FSM. It can be reused by the ppc2simulink side.
- The top level holds the hold register, NEW, OVR, CNT, and the read mux.

## Test plan
- Reset: assert OPB_Rst=0 mid-ack -> Sl_xferAck=0 and Sl_DBus=0 immediately; after release, a STATUS read returns 0x00000000.
- Single capture: user_valid with 0xDEADBEEF, then read DATA -> 0xDEADBEEF with a one-cycle ack; a following STATUS read returns 0x00010000 (NEW cleared by the DATA read).
- Overrun: 3 strobes with no read -> STATUS = 0x00030201; write STATUS -> the next read returns 0x00000001.
- Saturation and wrap: 300 back-to-back strobes -> OVR = 0xFF and CNT = 300; 65536 strobes -> CNT wraps to 0.
- Collision: user_valid on the DATA read ack cycle -> the read returns the old value, NEW = 1, and OVR is unchanged.
- Out-of-range address, and select held for 5 cycles -> no ack for the out-of-range access; the held select gives exactly one ack and Sl_DBus = 0 outside it.

Source files
------------

// File: rtl/opb_sw_reg_pkg.sv
// Shared definitions for the OPB software-register slaves: register offsets,
// STATUS field layout and the bus acknowledge FSM state encoding.
package opb_sw_reg_pkg;

    // Byte offsets of the two registers inside the window
    localparam logic [7:0] OFFSET_DATA   = 8'h00;
    localparam logic [7:0] OFFSET_STATUS = 8'h04;

    // Byte-address bit that tells DATA from STATUS; every other offset bit aliases
    localparam int REG_SEL_BIT = 2;

    // STATUS word layout
    localparam int STATUS_NEW_BIT   = 0;
    localparam int STATUS_OVR_LSB   = 8;
    localparam int STATUS_OVR_WIDTH = 8;
    localparam int STATUS_CNT_LSB   = 16;
    localparam int STATUS_CNT_WIDTH = 16;

    // Single-beat acknowledge sequence
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } ack_state_e;

    // Assemble the STATUS word; unused bits read as zero
    function automatic logic [31:0] pack_status(
        input logic                        new_flag,
        input logic [STATUS_OVR_WIDTH-1:0] ovr,
        input logic [STATUS_CNT_WIDTH-1:0] cnt
    );
        logic [31:0] word;
        word                                     = '0;
        word[STATUS_NEW_BIT]                     = new_flag;
        word[STATUS_OVR_LSB +: STATUS_OVR_WIDTH] = ovr;
        word[STATUS_CNT_LSB +: STATUS_CNT_WIDTH] = cnt;
        return word;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Address decode and single-beat acknowledge for an OPB slave. Read data is
// captured on the edge that samples the hit and driven only during the ACK
// cycle, so the slave contributes zero to the OR-bus at all other times.
module opb_slave_ack_fsm
    import opb_sw_reg_pkg::*;
#(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = '0,
    parameter logic [AWIDTH-1:0] HIGHADDR = 'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] abus,
    input  logic              select,
    input  logic              rnw,
    input  logic [DWIDTH-1:0] rd_data,
    output logic [DWIDTH-1:0] sl_dbus,
    output logic              xfer_ack,
    output logic              ack_rnw,
    output logic              ack_sel_status
);

    localparam logic [AWIDTH-1:0] SPAN = HIGHADDR - BASEADDR;

    ack_state_e        state_q, state_d;
    logic [DWIDTH-1:0] dbus_q, dbus_d;
    logic              rnw_q, rnw_d;
    logic              sel_status_q, sel_status_d;
    logic [AWIDTH:0]   addr_diff;
    logic              hit;

    // The extra borrow bit flags addresses below the base without a
    // compare-against-zero when the base is 0.
    assign addr_diff = {1'b0, abus} - {1'b0, BASEADDR};
    assign hit       = select && !addr_diff[AWIDTH] && (addr_diff[AWIDTH-1:0] <= SPAN);

    // State and registered bus-side outputs; reset clears them at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dbus_q       <= '0;
            rnw_q        <= 1'b0;
            sel_status_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dbus_q       <= dbus_d;
            rnw_q        <= rnw_d;
            sel_status_q <= sel_status_d;
        end
    end

    // Next state: one ACK cycle per hit, then wait for select to drop
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hit)     state_d = ST_ACK;
            ST_ACK:               state_d = ST_WAIT;
            ST_WAIT: if (!select) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // Capture read data and transfer attributes on the IDLE->ACK edge
    always_comb begin
        dbus_d       = '0;
        rnw_d        = rnw_q;
        sel_status_d = sel_status_q;
        if (state_q == ST_IDLE && hit) begin
            dbus_d       = rd_data;
            rnw_d        = rnw;
            sel_status_d = (abus[REG_SEL_BIT] == OFFSET_STATUS[REG_SEL_BIT]);
        end
    end

    assign sl_dbus        = dbus_q;
    assign xfer_ack       = (state_q == ST_ACK);
    assign ack_rnw        = rnw_q;
    assign ack_sel_status = sel_status_q;

endmodule

// File: rtl/opb_register_simulink2ppc_status.sv
// Status readback register: user logic strobes 32-bit words in, software
// reads the latest word plus a sticky NEW flag, an overrun count and a
// capture count over OPB.
module opb_register_simulink2ppc_status
    import opb_sw_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [31:0]               user_data_in,
    input  logic                      user_valid
);

    logic [C_OPB_AWIDTH-1:0]     abus_lsb;
    logic [C_OPB_DWIDTH-1:0]     dbus_lsb;
    logic [C_OPB_DWIDTH-1:0]     rd_mux;
    logic                        xfer_ack;
    logic                        ack_rnw;
    logic                        ack_sel_status;
    logic                        data_rd_ack;
    logic                        status_wr_ack;

    logic [31:0]                 hold_q, hold_d;
    logic                        new_q, new_d;
    logic [STATUS_OVR_WIDTH-1:0] ovr_q, ovr_d;
    logic [STATUS_CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Write data, byte enables and seqAddr carry no information for this slave
    logic unused_inputs;
    assign unused_inputs = ^{OPB_BE, OPB_DBus, OPB_seqAddr};

    // Bus vectors are MSB-first; work internally with LSB-indexed copies
    assign abus_lsb = OPB_ABus;
    assign Sl_DBus  = dbus_lsb;

    assign rd_mux = (abus_lsb[REG_SEL_BIT] == OFFSET_DATA[REG_SEL_BIT])
                    ? hold_q : pack_status(new_q, ovr_q, cnt_q);

    opb_slave_ack_fsm #(
        .AWIDTH   (C_OPB_AWIDTH),
        .DWIDTH   (C_OPB_DWIDTH),
        .BASEADDR (C_BASEADDR[C_OPB_AWIDTH-1:0]),
        .HIGHADDR (C_HIGHADDR[C_OPB_AWIDTH-1:0])
    ) u_ack_fsm (
        .clk            (OPB_Clk),
        .rst_n          (OPB_Rst),
        .abus           (abus_lsb),
        .select         (OPB_select),
        .rnw            (OPB_RNW),
        .rd_data        (rd_mux),
        .sl_dbus        (dbus_lsb),
        .xfer_ack       (xfer_ack),
        .ack_rnw        (ack_rnw),
        .ack_sel_status (ack_sel_status)
    );

    assign Sl_xferAck = xfer_ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Side effects land on the edge that ends the ACK cycle
    assign data_rd_ack   = xfer_ack && ack_rnw && !ack_sel_status;
    assign status_wr_ack = xfer_ack && !ack_rnw && ack_sel_status;

    // Hold register and counters
    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            hold_q <= '0;
            new_q  <= 1'b0;
            ovr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            hold_q <= hold_d;
            new_q  <= new_d;
            ovr_q  <= ovr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Capture wins over a DATA-read clear of NEW; a STATUS-write clear wins
    // over the counters; an overrun needs NEW to survive into this capture.
    always_comb begin
        hold_d = hold_q;
        new_d  = new_q;
        ovr_d  = ovr_q;
        cnt_d  = cnt_q;
        if (data_rd_ack) begin
            new_d = 1'b0;
        end
        if (user_valid) begin
            hold_d = user_data_in;
            new_d  = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (new_q && !data_rd_ack && (ovr_q != '1)) begin
                ovr_d = ovr_q + 1'b1;
            end
        end
        if (status_wr_ack) begin
            ovr_d = '0;
            cnt_d = '0;
        end
    end

endmodule

// File: tb/tb_opb_register_simulink2ppc_status.sv
// Directed bench for the status readback register.
module tb_opb_register_simulink2ppc_status;

    localparam logic [31:0] BASE        = 32'h0000_1000;
    localparam logic [31:0] HIGH        = 32'h0000_10FF;
    localparam logic [31:0] ADDR_DATA   = 32'h0000_1000;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_1004;

    logic        opb_clk = 1'b0;
    logic        opb_rst = 1'b0;
    logic [0:31] opb_abus = '0;
    logic [0:3]  opb_be = 4'hF;
    logic [0:31] opb_dbus = '0;
    logic        opb_rnw = 1'b0;
    logic        opb_select = 1'b0;
    logic        opb_seqaddr = 1'b0;
    logic [0:31] sl_dbus;
    logic        sl_xferack;
    logic        sl_errack;
    logic        sl_retry;
    logic        sl_toutsup;
    logic [31:0] user_data = '0;
    logic        user_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] rdata;
    int          acks;
    int          lat;
    logic        leak;

    opb_register_simulink2ppc_status #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_FAMILY     ("virtex6")
    ) dut (
        .OPB_Clk      (opb_clk),
        .OPB_Rst      (opb_rst),
        .OPB_ABus     (opb_abus),
        .OPB_BE       (opb_be),
        .OPB_DBus     (opb_dbus),
        .OPB_RNW      (opb_rnw),
        .OPB_select   (opb_select),
        .OPB_seqAddr  (opb_seqaddr),
        .Sl_DBus      (sl_dbus),
        .Sl_xferAck   (sl_xferack),
        .Sl_errAck    (sl_errack),
        .Sl_retry     (sl_retry),
        .Sl_toutSup   (sl_toutsup),
        .user_data_in (user_data),
        .user_valid   (user_valid)
    );

    always #5 opb_clk = ~opb_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One user strobe
    task automatic strobe(input logic [31:0] val);
        @(posedge opb_clk); #1;
        user_valid = 1'b1;
        user_data  = val;
        @(posedge opb_clk); #1;
        user_valid = 1'b0;
    endtask

    // Back-to-back strobes, n sampled edges
    task automatic strobe_burst(input int n);
        @(posedge opb_clk); #1;
        user_valid = 1'b1;
        user_data  = 32'h6666_6666;
        repeat (n) @(posedge opb_clk);
        #1;
        user_valid = 1'b0;
    endtask

    // One bus transfer with select held for six cycles; optionally strobe
    // user_valid during the ACK cycle.
    task automatic op(input logic [31:0] addr, input logic rnw_i, input logic collide,
                      input logic [31:0] cval, output logic [31:0] rd,
                      output int n_ack, output int first, output logic dleak);
        @(posedge opb_clk); #1;
        opb_abus   = addr;
        opb_rnw    = rnw_i;
        opb_dbus   = 32'hFFFF_FFFF;
        opb_select = 1'b1;
        rd    = '0;
        n_ack = 0;
        first = -1;
        dleak = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge opb_clk);
            if (collide && user_valid) user_valid = 1'b0;
            if (sl_xferack) begin
                n_ack++;
                if (first < 0) begin
                    first = i;
                    rd    = sl_dbus;
                end
                if (collide) begin
                    user_valid = 1'b1;
                    user_data  = cval;
                end
            end else if (sl_dbus != '0) begin
                dleak = 1'b1;
            end
        end
        opb_select = 1'b0;
        opb_abus   = '0;
        @(posedge opb_clk);
        @(posedge opb_clk); #1;
        $display("op addr=%08h rnw=%0d acks=%0d lat=%0d data=%08h", addr, rnw_i, n_ack, first, rd);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge opb_clk);
        @(negedge opb_clk);
        check("reset_ack", {31'b0, sl_xferack}, 32'h0);
        check("reset_dbus", sl_dbus, 32'h0);
        check("tieoffs", {29'b0, sl_errack, sl_retry, sl_toutsup}, 32'h0);
        @(posedge opb_clk); #1;
        opb_rst = 1'b1;

        // Reset asserted in the middle of an ACK cycle
        strobe(32'hA5A5_A5A5);
        @(posedge opb_clk); #1;
        opb_abus   = ADDR_DATA;
        opb_rnw    = 1'b1;
        opb_select = 1'b1;
        @(negedge opb_clk);
        @(negedge opb_clk);
        check("midack_ack_before", {31'b0, sl_xferack}, 32'h1);
        check("midack_dbus_before", sl_dbus, 32'hA5A5_A5A5);
        #2 opb_rst = 1'b0;
        #1;
        check("midack_ack_after_rst", {31'b0, sl_xferack}, 32'h0);
        check("midack_dbus_after_rst", sl_dbus, 32'h0);
        opb_select = 1'b0;
        opb_abus   = '0;
        @(posedge opb_clk);
        @(posedge opb_clk); #1;
        opb_rst = 1'b1;
        $display("reset pulse during ack");

        op(ADDR_STATUS, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("post_reset_status", rdata, 32'h0000_0000);
        check("post_reset_acks", acks, 1);
        op(ADDR_DATA, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("post_reset_data", rdata, 32'h0000_0000);

        // Single capture
        strobe(32'hDEAD_BEEF);
        op(ADDR_DATA, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("single_data", rdata, 32'hDEAD_BEEF);
        check("single_acks", acks, 1);
        check("single_latency", lat, 1);
        check("single_dbus_idle", {31'b0, leak}, 32'h0);
        op(ADDR_STATUS, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("single_status", rdata, 32'h0001_0000);

        // Overrun
        op(ADDR_STATUS, 1'b0, 1'b0, '0, rdata, acks, lat, leak);
        check("wr_status_acks", acks, 1);
        strobe(32'h1111_1111);
        strobe(32'h2222_2222);
        strobe(32'h3333_3333);
        op(ADDR_STATUS, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("overrun_status", rdata, 32'h0003_0201);
        op(ADDR_STATUS, 1'b0, 1'b0, '0, rdata, acks, lat, leak);
        op(ADDR_STATUS, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("status_after_clear", rdata, 32'h0000_0001);

        // Capture in the DATA read ACK cycle
        op(ADDR_DATA, 1'b1, 1'b1, 32'h4444_4444, rdata, acks, lat, leak);
        check("collide_rd_data", rdata, 32'h3333_3333);
        op(ADDR_STATUS, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("collide_rd_status", rdata, 32'h0001_0001);
        op(ADDR_DATA, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("collide_rd_newword", rdata, 32'h4444_4444);
        op(ADDR_STATUS, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("collide_rd_newclr", rdata, 32'h0001_0000);

        // Capture in the STATUS write ACK cycle
        op(ADDR_STATUS, 1'b0, 1'b1, 32'h5555_5555, rdata, acks, lat, leak);
        op(ADDR_STATUS, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("collide_wr_status", rdata, 32'h0000_0001);

        // Aliased offsets
        op(32'h0000_100C, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("alias_status", rdata, 32'h0000_0001);
        op(32'h0000_1008, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("alias_data", rdata, 32'h5555_5555);

        // Outside the window
        op(32'h0000_0FFC, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("below_base_acks", acks, 0);
        check("below_base_dbus", {31'b0, leak}, 32'h0);
        op(32'h0000_1100, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("above_high_acks", acks, 0);

        // Overrun saturation
        op(ADDR_STATUS, 1'b0, 1'b0, '0, rdata, acks, lat, leak);
        strobe_burst(300);
        $display("burst 300 strobes");
        op(ADDR_STATUS, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("saturate_status", rdata, 32'h012C_FF01);

        // Capture count wrap
        op(ADDR_STATUS, 1'b0, 1'b0, '0, rdata, acks, lat, leak);
        strobe_burst(65536);
        $display("burst 65536 strobes");
        op(ADDR_STATUS, 1'b1, 1'b0, '0, rdata, acks, lat, leak);
        check("wrap_status", rdata, 32'h0000_FF01);
        check("wrap_acks", acks, 1);
        check("wrap_dbus_idle", {31'b0, leak}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
